csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Sequencer and arbiter in front of the single-issue core's CSR register file (one read port, two write ports, one shared write enable; the file supports mstatus 0x300, mtvec 0x305, mepc 0x341 and mcause 0x342).
Runs the multi-cycle ecall trap-entry and mret sequences: reads mstatus, saves mepc/mcause, updates mstatus, then issues a PC redirect.
When idle, grants the CSR ports to the core's CSR-instruction path (csrrw/csrrs).
Holds the core stalled (busy) while a sequence runs.

Parameters:
XLEN, 32, data width of all CSR values and PCs.
NULL_ADDR, 12'h000, address driven on an unused write port; the CSR file maps it to its scratch slot.
MPP_M, 2'b11, mstatus.MPP value kept on entry and on mret (M-mode-only core).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
trap_req  in  1  ecall trap request; sampled only in IDLE
trap_cause  in  XLEN  mcause value; captured with trap_req
trap_pc  in  XLEN  PC of the trapping instruction; captured with trap_req
mret_req  in  1  mret request; sampled only in IDLE
req_ready  out  1  1 in IDLE; a request is accepted when req_ready & (trap_req | mret_req)
busy  out  1  state != IDLE; stalls the core
sw_wen  in  1  core CSR-instruction write request
sw_waddr  in  12  core CSR write address
sw_wdata  in  XLEN  core CSR write data
sw_raddr  in  12  core CSR read address
sw_ready  out  1  core CSR write/read granted this cycle
sw_rdata  out  XLEN  csr_rdata forwarded to the core
csr_wen  out  1  CSR file write enable
csr_waddr1  out  12  CSR write address, port 1
csr_wdata1  out  XLEN  CSR write data, port 1
csr_waddr2  out  12  CSR write address, port 2
csr_wdata2  out  XLEN  CSR write data, port 2
csr_raddr  out  12  CSR read address
csr_rdata  in  XLEN  combinational CSR read data
redirect_valid  out  1  one-cycle pulse; PC must load redirect_pc
redirect_pc  out  XLEN  new PC

Behaviour:
- States: IDLE, RD_STAT, T_SAVE, T_STAT, M_STAT, REDIR.
- Registered: state, is_trap, cause_q, pc_q, stat_q, target_q.
- All CSR-port outputs are combinational decodes of state and the registered values.
- Reset (async): state=IDLE and all registers 0. With sw inputs low, every output is 0 except req_ready=1 and sw_ready=1. Reset mid-sequence aborts it with no further CSR writes and no redirect.
- IDLE: ports pass through. csr_wen=sw_wen, waddr1/wdata1=sw_waddr/sw_wdata, waddr2=NULL_ADDR, csr_raddr=sw_raddr, sw_ready=1.
- IDLE with trap_req or mret_req high: sw_ready=0, csr_wen=0, and the sw write is dropped.
- IDLE exits: trap_req goes to RD_STAT with is_trap=1, cause_q=trap_cause, pc_q=trap_pc. Otherwise mret_req goes to RD_STAT with is_trap=0. If both are high, the trap wins and the mret is ignored.
- RD_STAT: csr_raddr=0x300, stat_q<=csr_rdata. Next state is T_SAVE if is_trap, else M_STAT.
- T_SAVE: csr_wen=1. Port 1 writes 0x341 <= pc_q; port 2 writes 0x342 <= cause_q. Next state T_STAT.
- T_STAT: csr_wen=1. Port 1 writes 0x300 <= stat_q with bit7 (MPIE)=stat_q[3], bit3 (MIE)=0, bits[12:11]=MPP_M. Port 2 = NULL_ADDR.
- T_STAT also reads: csr_raddr=0x305, target_q<={csr_rdata[XLEN-1:2],2'b00}. Next state REDIR.
- M_STAT: csr_wen=1. Port 1 writes 0x300 <= stat_q with bit3=stat_q[7], bit7=1, bits[12:11]=MPP_M. Port 2 = NULL_ADDR.
- M_STAT also reads: csr_raddr=0x341, target_q<=csr_rdata. Next state REDIR.
- REDIR: redirect_valid=1, redirect_pc=target_q, csr_wen=0. Next state IDLE. New requests are not sampled in REDIR.
- Outside IDLE: sw_ready=0, sw_wen is ignored, sw_rdata still reflects csr_raddr.
- Unused port addresses are always NULL_ADDR, never 0x300 to 0x342, so ports 1 and 2 never target the same CSR.
- Latency from accept edge to redirect cycle: trap 4 cycles, mret 3 cycles.

Decomposition:
- Shared package: CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342), mstatus bit indices (MIE=3, MPIE=7, MPP=12:11), state encoding.
- No sub-module is needed. The mstatus update function (trap and mret variants) can be a local function.

Test Plan:
- Reset: assert rst mid-T_SAVE -> state IDLE immediately, csr_wen=0, redirect_valid=0, req_ready=1.
- Trap with mstatus=0x1808, mtvec=0x80000400, trap_pc=0x80000100, cause=11 -> cycle 2: mepc=0x80000100 and mcause=11 written together; cycle 3: mstatus=0x1880; cycle 4: redirect_pc=0x80000400.
- Mret with mstatus=0x1880, mepc=0x80000104 -> cycle 2: mstatus=0x1888; cycle 3: redirect_pc=0x80000104; busy high for cycles 1 to 3.
- trap_req and mret_req high together with sw_wen=1 -> trap sequence runs, sw write dropped, mret ignored, exactly one redirect.
- Idle csrrw 0x305 <= 0x80000401 -> same-cycle csr_wen=1, waddr1=0x305, waddr2=0x000. A later trap then redirects to 0x80000400 (low bits masked).
- sw_wen held high through a trap sequence -> no sw writes while busy, and the write is granted on the cycle after REDIR.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants for the CSR trap/mret sequencer: CSR addresses,
// mstatus bit positions and the sequencer state encoding.
package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_STAT = 3'd1,
    T_SAVE  = 3'd2,
    T_STAT  = 3'd3,
    M_STAT  = 3'd4,
    REDIR   = 3'd5
  } state_t;

endpackage

// File: rtl/csr_trap_ctrl.sv
// Sequences ecall trap entry and mret through the CSR file, and hands the
// CSR ports to the core's CSR-instruction path whenever it is idle.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [11:0] NULL_ADDR = 12'h000,
  parameter logic [1:0]  MPP_M     = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_req,
  output logic            req_ready,
  output logic            busy,
  input  logic            sw_wen,
  input  logic [11:0]     sw_waddr,
  input  logic [XLEN-1:0] sw_wdata,
  input  logic [11:0]     sw_raddr,
  output logic            sw_ready,
  output logic [XLEN-1:0] sw_rdata,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr1,
  output logic [XLEN-1:0] csr_wdata1,
  output logic [11:0]     csr_waddr2,
  output logic [XLEN-1:0] csr_wdata2,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  state_t          state;
  logic            is_trap;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] stat_q;
  logic [XLEN-1:0] target_q;

  // Trap entry: stash MIE into MPIE, disable interrupts, stay in M-mode.
  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                 = s;
    r[MPIE_BIT]       = s[MIE_BIT];
    r[MIE_BIT]        = 1'b0;
    r[MPP_HI:MPP_LO]  = MPP_M;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                 = s;
    r[MIE_BIT]        = s[MPIE_BIT];
    r[MPIE_BIT]       = 1'b1;
    r[MPP_HI:MPP_LO]  = MPP_M;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      is_trap  <= 1'b0;
      cause_q  <= '0;
      pc_q     <= '0;
      stat_q   <= '0;
      target_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A trap outranks a simultaneous mret; the mret is simply dropped.
          if (trap_req) begin
            is_trap <= 1'b1;
            cause_q <= trap_cause;
            pc_q    <= trap_pc;
            state   <= RD_STAT;
          end else if (mret_req) begin
            is_trap <= 1'b0;
            state   <= RD_STAT;
          end
        end
        RD_STAT: begin
          stat_q <= csr_rdata;
          state  <= is_trap ? T_SAVE : M_STAT;
        end
        T_SAVE: state <= T_STAT;
        T_STAT: begin
          target_q <= {csr_rdata[XLEN-1:2], 2'b00};
          state    <= REDIR;
        end
        M_STAT: begin
          target_q <= csr_rdata;
          state    <= REDIR;
        end
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign sw_rdata = csr_rdata;

  always_comb begin
    req_ready      = 1'b0;
    sw_ready       = 1'b0;
    csr_wen        = 1'b0;
    csr_waddr1     = NULL_ADDR;
    csr_wdata1     = '0;
    csr_waddr2     = NULL_ADDR;
    csr_wdata2     = '0;
    csr_raddr      = NULL_ADDR;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        req_ready  = 1'b1;
        csr_waddr1 = sw_waddr;
        csr_wdata1 = sw_wdata;
        csr_raddr  = sw_raddr;
        // An accepted request claims the ports, so the core's write is dropped.
        if (!(trap_req || mret_req)) begin
          sw_ready = 1'b1;
          csr_wen  = sw_wen;
        end
      end
      RD_STAT: csr_raddr = CSR_MSTATUS;
      T_SAVE: begin
        csr_wen    = 1'b1;
        csr_waddr1 = CSR_MEPC;
        csr_wdata1 = pc_q;
        csr_waddr2 = CSR_MCAUSE;
        csr_wdata2 = cause_q;
      end
      T_STAT: begin
        csr_wen    = 1'b1;
        csr_waddr1 = CSR_MSTATUS;
        csr_wdata1 = trap_status(stat_q);
        csr_raddr  = CSR_MTVEC;
      end
      M_STAT: begin
        csr_wen    = 1'b1;
        csr_waddr1 = CSR_MSTATUS;
        csr_wdata1 = mret_status(stat_q);
        csr_raddr  = CSR_MEPC;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural CSR file attached
// to the write/read ports; expected values are hand-computed constants.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req;
  logic [31:0] trap_cause, trap_pc;
  logic        req_ready, busy;
  logic        sw_wen;
  logic [11:0] sw_waddr, sw_raddr;
  logic [31:0] sw_wdata, sw_rdata;
  logic        sw_ready;
  logic        csr_wen;
  logic [11:0] csr_waddr1, csr_waddr2, csr_raddr;
  logic [31:0] csr_wdata1, csr_wdata2, csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;
  int n_redir;
  int n_swbusy;

  logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0;

  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_req(mret_req), .req_ready(req_ready), .busy(busy),
    .sw_wen(sw_wen), .sw_waddr(sw_waddr), .sw_wdata(sw_wdata),
    .sw_raddr(sw_raddr), .sw_ready(sw_ready), .sw_rdata(sw_rdata),
    .csr_wen(csr_wen), .csr_waddr1(csr_waddr1), .csr_wdata1(csr_wdata1),
    .csr_waddr2(csr_waddr2), .csr_wdata2(csr_wdata2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Stand-in CSR file: combinational read, two write ports sharing one enable.
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      default: csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_wen) begin
      case (csr_waddr1)
        12'h300: m_mstatus <= csr_wdata1;
        12'h305: m_mtvec   <= csr_wdata1;
        12'h341: m_mepc    <= csr_wdata1;
        12'h342: m_mcause  <= csr_wdata1;
        default: ;
      endcase
      case (csr_waddr2)
        12'h300: m_mstatus <= csr_wdata2;
        12'h305: m_mtvec   <= csr_wdata2;
        12'h341: m_mepc    <= csr_wdata2;
        12'h342: m_mcause  <= csr_wdata2;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wen, input logic [11:0] waddr, input logic [31:0] wdata,
                               input logic [11:0] raddr);
    sw_wen   = wen;
    sw_waddr = waddr;
    sw_wdata = wdata;
    sw_raddr = raddr;
    #1;
  endtask

  initial begin
    rst = 1'b1; trap_req = 0; mret_req = 0; trap_cause = '0; trap_pc = '0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h000);
    #12;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_sw_ready", sw_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_csr_wen", csr_wen, 0);
    checkOutput("rst_redirect_valid", redirect_valid, 0);
    checkOutput("rst_redirect_pc", redirect_pc, 0);
    checkOutput("rst_waddr2", csr_waddr2, 0);
    rst = 1'b0;
    tick();

    // Idle csrrw pass-through to mtvec.
    applyStimulus(1'b1, 12'h305, 32'h8000_0401, 12'h000);
    checkOutput("idle_csr_wen", csr_wen, 1);
    checkOutput("idle_waddr1", csr_waddr1, 12'h305);
    checkOutput("idle_wdata1", csr_wdata1, 32'h8000_0401);
    checkOutput("idle_waddr2", csr_waddr2, 12'h000);
    checkOutput("idle_sw_ready", sw_ready, 1);
    tick();
    applyStimulus(1'b1, 12'h300, 32'h0000_1808, 12'h305);
    checkOutput("idle_read_mtvec", sw_rdata, 32'h8000_0401);
    tick();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h000);

    // Trap entry: mstatus 0x1808, mtvec 0x80000401, cause 11.
    trap_req = 1; trap_cause = 32'd11; trap_pc = 32'h8000_0100; #1;
    checkOutput("trap_accept_ready", req_ready, 1);
    checkOutput("trap_accept_sw_ready", sw_ready, 0);
    tick();
    trap_req = 0; trap_cause = '0; trap_pc = '0; #1;
    checkOutput("trap_c1_busy", busy, 1);
    checkOutput("trap_c1_raddr", csr_raddr, 12'h300);
    checkOutput("trap_c1_wen", csr_wen, 0);
    tick();
    checkOutput("trap_c2_wen", csr_wen, 1);
    checkOutput("trap_c2_waddr1", csr_waddr1, 12'h341);
    checkOutput("trap_c2_wdata1", csr_wdata1, 32'h8000_0100);
    checkOutput("trap_c2_waddr2", csr_waddr2, 12'h342);
    checkOutput("trap_c2_wdata2", csr_wdata2, 32'd11);
    tick();
    checkOutput("trap_c3_wen", csr_wen, 1);
    checkOutput("trap_c3_waddr1", csr_waddr1, 12'h300);
    checkOutput("trap_c3_wdata1", csr_wdata1, 32'h0000_1880);
    checkOutput("trap_c3_waddr2", csr_waddr2, 12'h000);
    checkOutput("trap_c3_raddr", csr_raddr, 12'h305);
    tick();
    checkOutput("trap_c4_redirect_valid", redirect_valid, 1);
    checkOutput("trap_c4_redirect_pc", redirect_pc, 32'h8000_0400);
    checkOutput("trap_c4_wen", csr_wen, 0);
    tick();
    checkOutput("trap_done_busy", busy, 0);
    checkOutput("trap_done_redirect_valid", redirect_valid, 0);
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h342);
    checkOutput("trap_mcause_stored", sw_rdata, 32'd11);

    // Mret: mstatus is now 0x1880; set mepc to 0x80000104 first.
    applyStimulus(1'b1, 12'h341, 32'h8000_0104, 12'h000);
    tick();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h000);
    mret_req = 1; #1;
    tick();
    mret_req = 0; #1;
    checkOutput("mret_c1_busy", busy, 1);
    checkOutput("mret_c1_raddr", csr_raddr, 12'h300);
    tick();
    checkOutput("mret_c2_busy", busy, 1);
    checkOutput("mret_c2_waddr1", csr_waddr1, 12'h300);
    checkOutput("mret_c2_wdata1", csr_wdata1, 32'h0000_1888);
    checkOutput("mret_c2_waddr2", csr_waddr2, 12'h000);
    checkOutput("mret_c2_raddr", csr_raddr, 12'h341);
    tick();
    checkOutput("mret_c3_busy", busy, 1);
    checkOutput("mret_c3_redirect_valid", redirect_valid, 1);
    checkOutput("mret_c3_redirect_pc", redirect_pc, 32'h8000_0104);
    tick();
    checkOutput("mret_done_busy", busy, 0);

    // Trap and mret together, with a csrrw to mtvec held high throughout.
    trap_req = 1; mret_req = 1; trap_cause = 32'd11; trap_pc = 32'h8000_0200;
    applyStimulus(1'b1, 12'h305, 32'h1234_5678, 12'h000);
    checkOutput("both_sw_ready", sw_ready, 0);
    checkOutput("both_csr_wen", csr_wen, 0);
    tick();
    trap_req = 0; mret_req = 0; trap_cause = '0; trap_pc = '0; #1;
    n_redir = 0;
    n_swbusy = 0;
    for (int i = 0; i < 6 && busy; i++) begin
      if (redirect_valid) begin
        n_redir++;
        checkOutput("both_redirect_pc", redirect_pc, 32'h8000_0400);
      end
      if (csr_wen && csr_waddr1 == 12'h305) n_swbusy++;
      if (csr_waddr2 == 12'h342) checkOutput("both_cause", csr_wdata2, 32'd11);
      if (csr_waddr1 == 12'h300) checkOutput("both_mstatus", csr_wdata1, 32'h0000_1880);
      tick();
    end
    checkOutput("both_redirect_count", n_redir, 1);
    checkOutput("both_sw_writes_while_busy", n_swbusy, 0);
    checkOutput("both_after_busy", busy, 0);
    checkOutput("held_sw_granted_ready", sw_ready, 1);
    checkOutput("held_sw_granted_wen", csr_wen, 1);
    checkOutput("held_sw_granted_waddr1", csr_waddr1, 12'h305);
    tick();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h305);
    checkOutput("held_sw_mtvec", sw_rdata, 32'h1234_5678);
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h341);
    checkOutput("both_mepc_stored", sw_rdata, 32'h8000_0200);

    // Reset in the middle of T_SAVE must abort without writing mepc.
    trap_req = 1; trap_cause = 32'd3; trap_pc = 32'h8000_0300; #1;
    tick();
    trap_req = 0; #1;
    tick();
    checkOutput("abort_in_tsave_wen", csr_wen, 1);
    rst = 1'b1; #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_csr_wen", csr_wen, 0);
    checkOutput("abort_redirect_valid", redirect_valid, 0);
    checkOutput("abort_req_ready", req_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_mepc_kept", sw_rdata, 32'h8000_0200);
    checkOutput("abort_no_redirect", redirect_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
